// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the display share arbiter.
// The BLANK state exists only when DISP_ARB_BLANK_EN is defined.
package disp_arb_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned NUM_HEX = 6;
  localparam int unsigned LED_W   = 10;
  localparam int unsigned HEX_W   = SEG_W * NUM_HEX;

  localparam logic [SEG_W-1:0] HEX_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_HPS,
    OWN_FPGA
  } owner_e;

`ifdef DISP_ARB_BLANK_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN_HPS,
    ST_OWN_FPGA,
    ST_BLANK
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN_HPS,
    ST_OWN_FPGA
  } state_e;
`endif

  // Payload driven onto the board pins
  typedef struct packed {
    logic [HEX_W-1:0] hex;
    logic [LED_W-1:0] ledr;
  } disp_data_t;

  // All segments off, all LEDs off
  function automatic disp_data_t disp_blank();
    disp_data_t d;
    d.hex  = {NUM_HEX{HEX_BLANK}};
    d.ledr = '0;
    return d;
  endfunction

endpackage

// File: rtl/display_share_arbiter_if.sv
// Requester-side bundle: two level requests, their display data and the grants.
interface display_share_arbiter_if;
  import disp_arb_pkg::*;

  logic             hps_req;
  logic [HEX_W-1:0] hps_hex;
  logic [LED_W-1:0] hps_ledr;
  logic             fpga_req;
  logic [HEX_W-1:0] fpga_hex;
  logic [LED_W-1:0] fpga_ledr;
  logic             hps_gnt;
  logic             fpga_gnt;

  // Requesters drive req/data and observe the grants
  modport master (
    output hps_req, hps_hex, hps_ledr, fpga_req, fpga_hex, fpga_ledr,
    input  hps_gnt, fpga_gnt
  );

  // Arbiter samples req/data and drives the grants
  modport slave (
    input  hps_req, hps_hex, hps_ledr, fpga_req, fpga_hex, fpga_ledr,
    output hps_gnt, fpga_gnt
  );
endinterface

// File: rtl/disp_arb_hold_timer.sv
// Saturating up-counter with synchronous clear; done_c flags count == LIMIT.
module disp_arb_hold_timer #(
  parameter int unsigned LIMIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic done_c
);
  localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and stick at LIMIT
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c = (cnt_q == CNT_W'(LIMIT));
endmodule

// File: rtl/display_share_arbiter.sv
// Two-requester owner arbiter for HEX0..HEX5 and LEDR with minimum hold time.
// Optional blanking gap on owner switches: define DISP_ARB_BLANK_EN.
module display_share_arbiter
  import disp_arb_pkg::*;
#(
  parameter int unsigned MIN_HOLD     = 5000000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  display_share_arbiter_if.slave bus,
  output logic [SEG_W-1:0]      HEX0,
  output logic [SEG_W-1:0]      HEX1,
  output logic [SEG_W-1:0]      HEX2,
  output logic [SEG_W-1:0]      HEX3,
  output logic [SEG_W-1:0]      HEX4,
  output logic [SEG_W-1:0]      HEX5,
  output logic [LED_W-1:0]      LEDR
);

  // Reject degenerate configurations at elaboration
  if (MIN_HOLD == 0 || BLANK_CYCLES == 0) begin : g_bad_param
    $error("display_share_arbiter: MIN_HOLD and BLANK_CYCLES must be >= 1");
  end

  state_e     state_q, state_d;
  owner_e     last_q, last_d;
  disp_data_t out_q, out_d;
  logic       hps_gnt_q, hps_gnt_d;
  logic       fpga_gnt_q, fpga_gnt_d;
  logic       hold_clr_c;
  logic       hold_done_c;

  // Ownership age; restarts on every entry to an OWN state
  disp_arb_hold_timer #(.LIMIT(MIN_HOLD)) u_hold (
    .clk    (CLOCK_50),
    .rst    (reset),
    .clr    (hold_clr_c),
    .done_c (hold_done_c)
  );

`ifdef DISP_ARB_BLANK_EN
  owner_e pend_q, pend_d;
  logic   blank_clr_c;
  logic   blank_done_c;

  // Blank gap length; done on the last blank cycle
  disp_arb_hold_timer #(.LIMIT(BLANK_CYCLES - 1)) u_blank (
    .clk    (CLOCK_50),
    .rst    (reset),
    .clr    (blank_clr_c),
    .done_c (blank_done_c)
  );
`endif

  // Next state, ownership history and registered output values
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
`ifdef DISP_ARB_BLANK_EN
    pend_d  = pend_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.hps_req && bus.fpga_req) begin
          state_d = (last_q == OWN_HPS) ? ST_OWN_FPGA : ST_OWN_HPS;
        end else if (bus.hps_req) begin
          state_d = ST_OWN_HPS;
        end else if (bus.fpga_req) begin
          state_d = ST_OWN_FPGA;
        end
      end
      ST_OWN_HPS: begin
        if (bus.fpga_req && (!bus.hps_req || hold_done_c)) begin
`ifdef DISP_ARB_BLANK_EN
          state_d = ST_BLANK;
          pend_d  = OWN_FPGA;
`else
          state_d = ST_OWN_FPGA;
`endif
        end else if (!bus.hps_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN_FPGA: begin
        if (bus.hps_req && (!bus.fpga_req || hold_done_c)) begin
`ifdef DISP_ARB_BLANK_EN
          state_d = ST_BLANK;
          pend_d  = OWN_HPS;
`else
          state_d = ST_OWN_HPS;
`endif
        end else if (!bus.fpga_req) begin
          state_d = ST_IDLE;
        end
      end
`ifdef DISP_ARB_BLANK_EN
      ST_BLANK: begin
        if (blank_done_c) begin
          if (pend_q == OWN_HPS) begin
            state_d = bus.hps_req ? ST_OWN_HPS : (bus.fpga_req ? ST_OWN_FPGA : ST_IDLE);
          end else begin
            state_d = bus.fpga_req ? ST_OWN_FPGA : (bus.hps_req ? ST_OWN_HPS : ST_IDLE);
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      if (state_d == ST_OWN_HPS) begin
        last_d = OWN_HPS;
      end else if (state_d == ST_OWN_FPGA) begin
        last_d = OWN_FPGA;
      end
    end

    // Hold counter only runs while staying in the same OWN state
    hold_clr_c = !((state_d == state_q) &&
                   (state_q == ST_OWN_HPS || state_q == ST_OWN_FPGA));
`ifdef DISP_ARB_BLANK_EN
    blank_clr_c = (state_q != ST_BLANK);
`endif

    hps_gnt_d  = (state_d == ST_OWN_HPS);
    fpga_gnt_d = (state_d == ST_OWN_FPGA);

    // Only the owner for the coming cycle reaches the pins
    unique case (state_d)
      ST_OWN_HPS: begin
        out_d.hex  = bus.hps_hex;
        out_d.ledr = bus.hps_ledr;
      end
      ST_OWN_FPGA: begin
        out_d.hex  = bus.fpga_hex;
        out_d.ledr = bus.fpga_ledr;
      end
      default: out_d = disp_blank();
    endcase
  end

  // State and output registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= OWN_FPGA;
      out_q      <= disp_blank();
      hps_gnt_q  <= 1'b0;
      fpga_gnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      out_q      <= out_d;
      hps_gnt_q  <= hps_gnt_d;
      fpga_gnt_q <= fpga_gnt_d;
    end
  end

`ifdef DISP_ARB_BLANK_EN
  // Owner waiting at the end of the blank gap
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pend_q <= OWN_NONE;
    end else begin
      pend_q <= pend_d;
    end
  end
`endif

  assign bus.hps_gnt  = hps_gnt_q;
  assign bus.fpga_gnt = fpga_gnt_q;

  assign HEX0 = out_q.hex[0*SEG_W +: SEG_W];
  assign HEX1 = out_q.hex[1*SEG_W +: SEG_W];
  assign HEX2 = out_q.hex[2*SEG_W +: SEG_W];
  assign HEX3 = out_q.hex[3*SEG_W +: SEG_W];
  assign HEX4 = out_q.hex[4*SEG_W +: SEG_W];
  assign HEX5 = out_q.hex[5*SEG_W +: SEG_W];
  assign LEDR = out_q.ledr;

endmodule
